avr_hvpp_seq: RTL and testbench
===============================

AVR_HVPP_SEQ -- requirements
Module: avr_hvpp_seq

Interface
REQ-001 Parameter SETUP_CYC, default 2, is the number of cycles control/data lines are stable before a strobe (1..15).
REQ-002 Parameter PULSE_CYC, default 4, is the width of the XTAL/WR/PAGEL strobe in cycles (1..15).
REQ-003 Parameter TIMEOUT_CYC, default 50000, is the maximum number of WAIT_RDY cycles (1..65535).
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in/out  1/1  command handshake.
REQ-007 cmd_op  in  2  0=LOAD, 1=PAGEL, 2=WRITE, 3=READ.
REQ-008 cmd_xa  in  2  XA1:XA0 value for the command (00 addr, 01 data, 10 cmd).
REQ-009 cmd_bs1, cmd_bs2  in  1 each  byte-select values for the command.
REQ-010 cmd_data  in  8  byte driven to the DUT on LOAD.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; there is no backpressure.
REQ-012 rsp_data  out  8  byte sampled on READ; 0 for other ops.
REQ-013 rsp_timeout  out  1  WRITE ended without RDY; valid with rsp_valid.
REQ-014 busy  out  1  state != IDLE.
REQ-015 dut_xa0, dut_xa1, dut_bs1, dut_bs2  out  1  DUT select lines.
REQ-016 dut_xtal, dut_pagel  out  1  active-high strobes.
REQ-017 dut_wr, dut_oe  out  1  active-low strobes.
REQ-018 dut_data_out / dut_data_oe  out  8/1  DUT data bus drive value and enable.
REQ-019 dut_data_in  in  8  DUT data bus sample.
REQ-020 dut_rdy  in  1  asynchronous RDY/BSY pin.

Function
REQ-021 cmd_ready SHALL equal (state==IDLE) and rst low; a command is accepted on the cycle T where cmd_valid && cmd_ready.
REQ-022 States SHALL be IDLE, SETUP, PULSE, HOLD, WAIT_RDY; transitions are IDLE->SETUP on accept, SETUP->PULSE after SETUP_CYC cycles, PULSE->HOLD after PULSE_CYC cycles, HOLD->IDLE after 1 cycle (HOLD->WAIT_RDY for WRITE), and WAIT_RDY->IDLE on RDY or timeout.
REQ-023 From T+1 until the return to IDLE, dut_xa*/dut_bs* SHALL hold the latched cmd_xa/cmd_bs*; in IDLE they SHALL hold their last values.
REQ-024 LOAD: dut_data_out=cmd_data and dut_data_oe=1 from T+1 through HOLD; dut_xtal=1 during PULSE only.
REQ-025 PAGEL: dut_pagel=1 during PULSE only; dut_data_oe=0.
REQ-026 WRITE: dut_wr=0 during PULSE only, then WAIT_RDY.
REQ-027 READ: dut_oe=0 from SETUP through PULSE; dut_data_in SHALL be captured into rsp_data on the last PULSE cycle; dut_oe=1 in HOLD.
REQ-028 dut_data_oe=1 and dut_oe=0 SHALL never coincide (bus contention forbidden).
REQ-029 dut_rdy SHALL pass through a 2-flop synchronizer; WAIT_RDY SHALL ignore it for the first 4 cycles, then exit on the first synchronized 1.
REQ-030 A WAIT_RDY cycle counter SHALL exit with rsp_timeout=1 when it reaches TIMEOUT_CYC; counter width is 16 bits with no wrap.
REQ-031 rsp_valid SHALL pulse in the first IDLE cycle after completion, i.e. at T+SETUP_CYC+PULSE_CYC+2 for LOAD/PAGEL/READ, and cmd_ready is high in the same cycle.
REQ-032 A command presented in the rsp_valid cycle SHALL be accepted; this gives back-to-back operation with no idle gap.

Reset
REQ-033 On rst: state=IDLE; cmd_ready=0; rsp_valid=0; rsp_timeout=0; rsp_data=0; busy=0; dut_wr=1; dut_oe=1; dut_xtal=0; dut_pagel=0; dut_data_oe=0; dut_data_out=0; dut_xa*/dut_bs*=0; counters and synchronizer=0.
REQ-034 rst mid-operation SHALL abort the operation with no rsp_valid, and all DUT lines SHALL reach the idle values on the next edge.

Structure
REQ-035 Package avr_hvpp_pkg SHALL hold the op codes, the XA encodings, the state enum and the RDY ignore count (4).
REQ-036 One sub-module, hvpp_delay_cnt (loadable down-counter with a done flag), SHALL be shared by the SETUP, PULSE and WAIT_RDY timing.

Verification
REQ-037 LOAD xa=01, data=0xA5 at T with defaults -> data_oe 1 from T+1..T+7, xtal high T+3..T+6, rsp_valid at T+8 with rsp_data=0.
REQ-038 READ bs1=1, DUT drives 0x3C -> oe low T+1..T+6, data_oe 0 throughout, rsp_data=0x3C at T+8.
REQ-039 WRITE, dut_rdy low for 20 cycles after the WR pulse then high -> wr low T+3..T+6, rsp_valid with rsp_timeout=0 about 3 cycles after RDY rises.
REQ-040 WRITE with TIMEOUT_CYC=100 and dut_rdy stuck low -> rsp_valid with rsp_timeout=1 after exactly 100 WAIT_RDY cycles.
REQ-041 rst asserted during a PULSE of LOAD -> next edge xtal=0, data_oe=0, wr=oe=1, no rsp_valid.
REQ-042 Two LOADs back-to-back with cmd_valid held high -> second accepted at T+8, second xtal pulse T+11..T+14.

Source files
------------

// File: rtl/avr_hvpp_pkg.sv
// Shared definitions for the AVR high-voltage parallel programming sequencer.
//   - hvpp_op_e    : command op codes carried on cmd_op
//   - xa_t / XA_*  : XA1:XA0 action encodings
//   - hvpp_state_e : sequencer FSM states
//   - RDY_IGNORE   : WAIT_RDY cycles during which the synchronized RDY is ignored
//   - op_drives_bus: true for ops that drive the target data bus
package avr_hvpp_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_PAGEL = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } hvpp_op_e;

  typedef logic [1:0] xa_t;

  localparam xa_t XA_ADDR = 2'b00;
  localparam xa_t XA_DATA = 2'b01;
  localparam xa_t XA_CMD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT_RDY = 3'd4
  } hvpp_state_e;

  // The target keeps RDY low for a short while after WR; ignore it this long.
  localparam logic [15:0] RDY_IGNORE = 16'd4;

  // Only LOAD puts a byte on the shared data bus.
  function automatic logic op_drives_bus(input hvpp_op_e op);
    return (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/avr_hvpp_seq_if.sv
// Command/response channel of the HVPP sequencer.
//   master: issues commands (cmd_valid, cmd_op, cmd_xa, cmd_bs1, cmd_bs2, cmd_data),
//           observes cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
//   slave : the sequencer side of the same signals
interface avr_hvpp_seq_if;
  import avr_hvpp_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  xa_t        cmd_xa;
  logic       cmd_bs1;
  logic       cmd_bs2;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_xa, cmd_bs1, cmd_bs2, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_xa, cmd_bs1, cmd_bs2, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy
  );

endinterface

// File: rtl/hvpp_delay_cnt.sv
// Loadable down-counter shared by all timed phases of the sequencer.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load; the phase then lasts load_val cycles
//   count     : current count, saturates at 0
//   done      : high on the last cycle of a phase (count == 1)
module hvpp_delay_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] cnt_r;

  // Down-counter register: load wins, otherwise count toward zero and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = cnt_r;
  assign done  = (cnt_r == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/avr_hvpp_seq.sv
// HVPP strobe sequencer: turns one command into the timed select/strobe/data
// waveform on the target's parallel programming pins.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : command handshake and single-cycle response
//   dut_xa0/xa1, dut_bs1/bs2 : target select lines, held between commands
//   dut_xtal, dut_pagel      : active-high strobes
//   dut_wr, dut_oe           : active-low strobes
//   dut_data_out/dut_data_oe : data bus drive value and enable
//   dut_data_in              : data bus sample
//   dut_rdy                  : asynchronous RDY/BSY pin
module avr_hvpp_seq
  import avr_hvpp_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  avr_hvpp_seq_if.slave        bus,
  output logic                 dut_xa0,
  output logic                 dut_xa1,
  output logic                 dut_bs1,
  output logic                 dut_bs2,
  output logic                 dut_xtal,
  output logic                 dut_pagel,
  output logic                 dut_wr,
  output logic                 dut_oe,
  output logic [7:0]           dut_data_out,
  output logic                 dut_data_oe,
  input  logic [7:0]           dut_data_in,
  input  logic                 dut_rdy
);

  localparam logic [15:0] SETUP_LD   = 16'(SETUP_CYC);
  localparam logic [15:0] PULSE_LD   = 16'(PULSE_CYC);
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_CYC);

  hvpp_state_e state_r;
  hvpp_state_e state_next_s;
  hvpp_op_e    op_r;
  hvpp_op_e    op_eff_s;
  hvpp_op_e    cmd_op_s;

  logic        accept_s;
  logic        cmd_ready_s;
  logic        cnt_load_s;
  logic [15:0] cnt_load_val_s;
  logic [15:0] cnt_value_s;
  logic        cnt_done_s;
  logic        rdy_meta_r;
  logic        rdy_sync_r;
  logic [16:0] wait_elapsed_s;
  logic        rdy_window_s;
  logic        complete_s;
  logic        timeout_s;
  logic        capture_s;

  logic        xtal_nx_s;
  logic        pagel_nx_s;
  logic        wr_nx_s;
  logic        oe_nx_s;
  logic        data_oe_nx_s;

  logic        busy_r;
  logic        rsp_valid_r;
  logic        rsp_timeout_r;
  logic [7:0]  rsp_data_r;
  xa_t         xa_r;
  logic        bs1_r;
  logic        bs2_r;
  logic        xtal_r;
  logic        pagel_r;
  logic        wr_r;
  logic        oe_r;
  logic        data_oe_r;
  logic [7:0]  data_out_r;

  assign cmd_op_s    = hvpp_op_e'(bus.cmd_op);
  assign cmd_ready_s = (state_r == ST_IDLE) && !rst;
  assign accept_s    = bus.cmd_valid && cmd_ready_s;
  // The op being accepted this cycle must shape the first SETUP cycle.
  assign op_eff_s    = accept_s ? cmd_op_s : op_r;

  // Cycles already spent in WAIT_RDY, derived from the shared down-counter.
  assign wait_elapsed_s = {1'b0, TIMEOUT_LD} - {1'b0, cnt_value_s};
  assign rdy_window_s   = (wait_elapsed_s >= {1'b0, RDY_IGNORE});

  hvpp_delay_cnt #(.WIDTH(16)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .count    (cnt_value_s),
    .done     (cnt_done_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic, phase-counter reloads and completion events.
  always_comb begin
    state_next_s   = state_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = 16'd0;
    complete_s     = 1'b0;
    timeout_s      = 1'b0;
    capture_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s   = ST_SETUP;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = SETUP_LD;
        end else begin
          state_next_s   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_done_s) begin
          state_next_s   = ST_PULSE;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = PULSE_LD;
        end else begin
          state_next_s   = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (cnt_done_s) begin
          state_next_s = ST_HOLD;
          capture_s    = (op_r == OP_READ);
        end else begin
          state_next_s = ST_PULSE;
        end
      end
      ST_HOLD: begin
        if (op_r == OP_WRITE) begin
          state_next_s   = ST_WAIT_RDY;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = TIMEOUT_LD;
        end else begin
          state_next_s   = ST_IDLE;
          complete_s     = 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        // A real RDY wins over a timeout landing in the same cycle.
        if (rdy_sync_r && rdy_window_s) begin
          state_next_s = ST_IDLE;
          complete_s   = 1'b1;
        end else if (cnt_done_s) begin
          state_next_s = ST_IDLE;
          complete_s   = 1'b1;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ST_WAIT_RDY;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Strobe values for the coming cycle, decoded from the next state so the
  // registered pins line up exactly with the state they belong to.
  always_comb begin
    xtal_nx_s    = 1'b0;
    pagel_nx_s   = 1'b0;
    wr_nx_s      = 1'b1;
    oe_nx_s      = 1'b1;
    data_oe_nx_s = 1'b0;
    case (state_next_s)
      ST_SETUP: begin
        oe_nx_s      = !(op_eff_s == OP_READ);
        data_oe_nx_s = op_drives_bus(op_eff_s);
      end
      ST_PULSE: begin
        xtal_nx_s    = (op_eff_s == OP_LOAD);
        pagel_nx_s   = (op_eff_s == OP_PAGEL);
        wr_nx_s      = !(op_eff_s == OP_WRITE);
        oe_nx_s      = !(op_eff_s == OP_READ);
        data_oe_nx_s = op_drives_bus(op_eff_s);
      end
      ST_HOLD: begin
        data_oe_nx_s = op_drives_bus(op_eff_s);
      end
      default: begin
        xtal_nx_s    = 1'b0;
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous RDY pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_meta_r <= 1'b0;
      rdy_sync_r <= 1'b0;
    end else begin
      rdy_meta_r <= dut_rdy;
      rdy_sync_r <= rdy_meta_r;
    end
  end

  // Latched command, select lines, strobes and data bus drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= OP_LOAD;
      xa_r       <= XA_ADDR;
      bs1_r      <= 1'b0;
      bs2_r      <= 1'b0;
      data_out_r <= 8'h00;
      xtal_r     <= 1'b0;
      pagel_r    <= 1'b0;
      wr_r       <= 1'b1;
      oe_r       <= 1'b1;
      data_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r       <= cmd_op_s;
        xa_r       <= bus.cmd_xa;
        bs1_r      <= bus.cmd_bs1;
        bs2_r      <= bus.cmd_bs2;
        data_out_r <= op_drives_bus(cmd_op_s) ? bus.cmd_data : 8'h00;
      end
      xtal_r    <= xtal_nx_s;
      pagel_r   <= pagel_nx_s;
      wr_r      <= wr_nx_s;
      oe_r      <= oe_nx_s;
      data_oe_r <= data_oe_nx_s;
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  // Response registers: one-cycle pulse on completion, read byte captured on
  // the last PULSE cycle and cleared at the start of every command.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r   <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_data_r    <= 8'h00;
    end else begin
      rsp_valid_r   <= complete_s;
      rsp_timeout_r <= timeout_s;
      if (accept_s) begin
        rsp_data_r <= 8'h00;
      end else if (capture_s) begin
        rsp_data_r <= dut_data_in;
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_timeout = rsp_timeout_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.busy        = busy_r;

  assign dut_xa0      = xa_r[0];
  assign dut_xa1      = xa_r[1];
  assign dut_bs1      = bs1_r;
  assign dut_bs2      = bs2_r;
  assign dut_xtal     = xtal_r;
  assign dut_pagel    = pagel_r;
  assign dut_wr       = wr_r;
  assign dut_oe       = oe_r;
  assign dut_data_out = data_out_r;
  assign dut_data_oe  = data_oe_r;

endmodule

// File: tb/tb_avr_hvpp_seq.sv
// Self-checking bench for avr_hvpp_seq (SETUP_CYC=2, PULSE_CYC=4, TIMEOUT_CYC=100).
module tb_avr_hvpp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       dut_xa0, dut_xa1, dut_bs1, dut_bs2;
  logic       dut_xtal, dut_pagel, dut_wr, dut_oe;
  logic [7:0] dut_data_out;
  logic       dut_data_oe;
  logic [7:0] dut_data_in;
  logic       dut_rdy;

  int checks   = 0;
  int failures = 0;
  logic contention_seen = 1'b0;

  always #5 clk = ~clk;

  avr_hvpp_seq_if bus ();

  avr_hvpp_seq #(
    .SETUP_CYC   (2),
    .PULSE_CYC   (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dut_xa0      (dut_xa0),
    .dut_xa1      (dut_xa1),
    .dut_bs1      (dut_bs1),
    .dut_bs2      (dut_bs2),
    .dut_xtal     (dut_xtal),
    .dut_pagel    (dut_pagel),
    .dut_wr       (dut_wr),
    .dut_oe       (dut_oe),
    .dut_data_out (dut_data_out),
    .dut_data_oe  (dut_data_oe),
    .dut_data_in  (dut_data_in),
    .dut_rdy      (dut_rdy)
  );

  // Bus contention watch: driving the bus while the target drives it.
  always @(negedge clk) begin
    if (dut_data_oe === 1'b1 && dut_oe === 1'b0) contention_seen <= 1'b1;
  end

  typedef struct {
    logic [1:0] op;
    logic [1:0] xa;
    logic       bs1;
    logic       bs2;
    logic [7:0] data;
    logic [7:0] din;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] xa, input logic b1,
                       input logic b2, input logic [7:0] data);
    bus.cmd_op    = op;
    bus.cmd_xa    = xa;
    bus.cmd_bs1   = b1;
    bus.cmd_bs2   = b2;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
  endtask

  // {busy, xtal, pagel, wr, oe, data_oe, rsp_valid, xa1, xa0, bs1, bs2}
  function automatic logic [10:0] obs();
    return {bus.busy, dut_xtal, dut_pagel, dut_wr, dut_oe, dut_data_oe,
            bus.rsp_valid, dut_xa1, dut_xa0, dut_bs1, dut_bs2};
  endfunction

  // Expected pins k cycles after acceptance for LOAD/PAGEL/READ.
  function automatic logic [10:0] exp_obs(input logic [1:0] op, input logic [1:0] xa,
                                          input logic b1, input logic b2, input int k);
    logic in_pulse, busy_e, xtal_e, pagel_e, wr_e, oe_e, doe_e, rv_e;
    in_pulse = (k >= 3) && (k <= 6);
    busy_e   = (k >= 1) && (k <= 7);
    xtal_e   = (op == 2'd0) && in_pulse;
    pagel_e  = (op == 2'd1) && in_pulse;
    wr_e     = !((op == 2'd2) && in_pulse);
    oe_e     = !((op == 2'd3) && (k >= 1) && (k <= 6));
    doe_e    = (op == 2'd0) && busy_e;
    rv_e     = (k == 8);
    return {busy_e, xtal_e, pagel_e, wr_e, oe_e, doe_e, rv_e, xa[1], xa[0], b1, b2};
  endfunction

  localparam logic [10:0] RESET_OBS = 11'b000_1100_0000;

  initial begin
    int n;
    logic seen;

    vecs[0] = '{2'd0, 2'b01, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{2'd3, 2'b00, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h3C};
    vecs[2] = '{2'd1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'h55, 8'h00};
    vecs[3] = '{2'd0, 2'b10, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00};
    vecs[4] = '{2'd3, 2'b00, 1'b0, 1'b1, 8'h00, 8'hC3, 8'hC3};
    vecs[5] = '{2'd0, 2'b00, 1'b0, 1'b1, 8'h5A, 8'h99, 8'h00};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0; bus.cmd_xa = 2'd0; bus.cmd_bs1 = 1'b0; bus.cmd_bs2 = 1'b0;
    bus.cmd_data = 8'h00;
    dut_data_in = 8'h00;
    dut_rdy = 1'b0;
    repeat (3) tick();

    // Reset state.
    chk("reset_pins", obs(), RESET_OBS);
    chk("reset_ready", bus.cmd_ready, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_timeout", bus.rsp_timeout, 0);
    chk("reset_data_out", dut_data_out, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", bus.cmd_ready, 1);
    tick();

    // Table of single LOAD/PAGEL/READ commands.
    for (int i = 0; i < 6; i++) begin
      dut_data_in = vecs[i].din;
      issue(vecs[i].op, vecs[i].xa, vecs[i].bs1, vecs[i].bs2, vecs[i].data);
      chk($sformatf("v%0d_accept_ready", i), bus.cmd_ready, 1);
      tick();
      bus.cmd_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        chk($sformatf("v%0d_k%0d_pins", i, k), obs(),
            exp_obs(vecs[i].op, vecs[i].xa, vecs[i].bs1, vecs[i].bs2, k));
        if (vecs[i].op == 2'd0 && k >= 1 && k <= 7)
          chk($sformatf("v%0d_k%0d_data_out", i, k), dut_data_out, vecs[i].data);
        if (k == 8) begin
          chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].exp_rsp);
          chk($sformatf("v%0d_ready_at_rsp", i), bus.cmd_ready, 1);
          chk($sformatf("v%0d_rsp_timeout", i), bus.rsp_timeout, 0);
        end
        tick();
      end
    end

    // WRITE: RDY low for 20 cycles after the WR pulse, then high.
    issue(2'd2, 2'b10, 1'b0, 1'b0, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("wr_k%0d_wr", k), dut_wr, (k >= 3 && k <= 6) ? 0 : 1);
      chk($sformatf("wr_k%0d_data_oe", k), dut_data_oe, 0);
      tick();
    end
    for (int k = 8; k < 27; k++) tick();
    chk("wr_busy_waiting", bus.busy, 1);
    dut_rdy = 1'b1;
    n = 27;
    while (!bus.rsp_valid && n < 60) begin
      tick();
      n++;
    end
    chk("wr_rdy_rsp_cycle", n, 30);
    chk("wr_rdy_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rdy_timeout", bus.rsp_timeout, 0);
    chk("wr_rdy_rsp_data", bus.rsp_data, 0);
    dut_rdy = 1'b0;
    repeat (4) tick();

    // WRITE with RDY stuck low: timeout after exactly 100 WAIT_RDY cycles.
    issue(2'd2, 2'b10, 1'b0, 1'b0, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("wr_to_rsp_cycle", n, 108);
    chk("wr_to_timeout", bus.rsp_timeout, 1);
    tick();
    chk("wr_to_timeout_clears", bus.rsp_timeout, 0);

    // WRITE with RDY already high: the first 4 WAIT_RDY cycles ignore it.
    dut_rdy = 1'b1;
    repeat (3) tick();
    issue(2'd2, 2'b10, 1'b0, 1'b0, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 60) begin
      tick();
      n++;
    end
    chk("wr_early_rsp_cycle", n, 13);
    chk("wr_early_timeout", bus.rsp_timeout, 0);
    dut_rdy = 1'b0;
    repeat (3) tick();

    // Reset during the PULSE of a LOAD.
    issue(2'd0, 2'b01, 1'b1, 1'b0, 8'h77);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    chk("rst_mid_xtal_before", dut_xtal, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready_low", bus.cmd_ready, 0);
    tick();
    chk("rst_mid_pins", obs(), RESET_OBS);
    chk("rst_mid_data_out", dut_data_out, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst_mid_no_rsp", seen, 0);

    // Two LOADs back-to-back with cmd_valid held high.
    issue(2'd0, 2'b01, 1'b0, 1'b0, 8'h11);
    chk("b2b_first_ready", bus.cmd_ready, 1);
    tick();
    issue(2'd0, 2'b00, 1'b1, 1'b0, 8'h22);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("b2b_k%0d_ready", k), bus.cmd_ready, 0);
      if (k == 3) chk("b2b_first_data", dut_data_out, 8'h11);
      tick();
    end
    chk("b2b_k8_rsp_valid", bus.rsp_valid, 1);
    chk("b2b_k8_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b_k9_sel", {dut_xa1, dut_xa0, dut_bs1, dut_bs2}, 4'b0010);
    for (int k = 9; k <= 16; k++) begin
      chk($sformatf("b2b_k%0d_xtal", k), dut_xtal, (k >= 11 && k <= 14) ? 1 : 0);
      if (k == 11) chk("b2b_second_data", dut_data_out, 8'h22);
      if (k == 16) chk("b2b_k16_rsp_valid", bus.rsp_valid, 1);
      tick();
    end
    chk("b2b_no_third", bus.busy, 0);

    chk("no_contention", contention_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
